// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation control sequencer: FSM states, end-reason codes
// and the helper that classifies terminal states.
package sim_ctrl_pkg;

    localparam int unsigned HOLD_CNT_W = 16;
    localparam int unsigned REASON_W   = 2;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [REASON_W-1:0] {
        RSN_NONE    = 2'd0,
        RSN_FAILURE = 2'd1,
        RSN_TIMEOUT = 2'd2
    } reason_e;

    function automatic logic is_terminal(input state_e s);
        return (s == ST_PASS) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/sim_ctrl_sequencer_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sim_ctrl_sequencer.sv
// Simulation run controller: holds the harness in reset, then watches pass/fail/timeout
// events, gates the waveform dump window and latches the final verdict.
module sim_ctrl_sequencer
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    input  logic [CNT_W-1:0]    max_cycles,
    input  logic [CNT_W-1:0]    dump_start,
    input  logic                success_in,
    input  logic                failure_in,
    output logic                harness_resetn,
    output logic                dump_en,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [REASON_W-1:0] reason,
    output logic [CNT_W-1:0]    cycle_count
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESET_CYCLES - 1);

    state_e                state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]      max_cycles_q, max_cycles_d;
    logic [CNT_W-1:0]      dump_start_q, dump_start_d;
    logic                  harness_resetn_q, harness_resetn_d;
    logic                  dump_en_q, dump_en_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    reason_e               reason_q, reason_d;
    logic                  count_en;
    logic                  timeout;
    logic                  live_d;

    assign count_en = (state_q == ST_HOLD) || (state_q == ST_RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .en_i    (count_en),
        .count_o (cycle_count)
    );

    assign timeout = (max_cycles_q != '0) && (cycle_count > max_cycles_q);

    // Next state plus registered-output next values; outputs follow the state being entered.
    always_comb begin
        state_d          = state_q;
        hold_cnt_d       = hold_cnt_q;
        max_cycles_d     = max_cycles_q;
        dump_start_d     = dump_start_q;
        reason_d         = reason_q;
        harness_resetn_d = 1'b0;
        dump_en_d        = 1'b0;
        done_d           = 1'b0;
        pass_d           = 1'b0;
        fail_d           = 1'b0;
        live_d           = 1'b0;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
                if (cfg_valid) begin
                    max_cycles_d = max_cycles;
                    dump_start_d = dump_start;
                end
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (failure_in) begin
                    state_d  = ST_FAIL;
                    reason_d = RSN_FAILURE;
                end else if (timeout) begin
                    state_d  = ST_FAIL;
                    reason_d = RSN_TIMEOUT;
                end else if (success_in) begin
                    state_d  = ST_PASS;
                    reason_d = RSN_NONE;
                end
            end
            default: begin
            end
        endcase

        live_d           = !is_terminal(state_d);
        harness_resetn_d = (state_d != ST_HOLD);
        // Dump window follows the config as it stands after this edge, so a load in HOLD takes effect at once.
        dump_en_d        = live_d && ((dump_start_d == '0) || (cycle_count >= dump_start_d));
        done_d           = !live_d;
        pass_d           = (state_d == ST_PASS);
        fail_d           = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_HOLD;
            hold_cnt_q       <= '0;
            max_cycles_q     <= '0;
            dump_start_q     <= '0;
            harness_resetn_q <= 1'b0;
            dump_en_q        <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_q           <= 1'b0;
            reason_q         <= RSN_NONE;
        end else begin
            state_q          <= state_d;
            hold_cnt_q       <= hold_cnt_d;
            max_cycles_q     <= max_cycles_d;
            dump_start_q     <= dump_start_d;
            harness_resetn_q <= harness_resetn_d;
            dump_en_q        <= dump_en_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            fail_q           <= fail_d;
            reason_q         <= reason_d;
        end
    end

    assign harness_resetn = harness_resetn_q;
    assign dump_en        = dump_en_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign reason         = reason_q;

endmodule

// File: tb/tb_sim_ctrl_sequencer.sv
// Bench for sim_ctrl_sequencer: two instances (wide counter, and a 4-bit saturating one)
// driven by directed and random runs and compared every cycle to a cycle-count based model.
module tb_sim_ctrl_sequencer;

    localparam int unsigned RC0 = 4;
    localparam int unsigned W0  = 32;
    localparam int unsigned RC1 = 3;
    localparam int unsigned W1  = 4;
    localparam int unsigned NONE = 9999;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic          success_in = 1'b0;
    logic          failure_in = 1'b0;
    logic [W0-1:0] max_cycles = '0;
    logic [W0-1:0] dump_start = '0;

    logic          d0_hres, d0_dump, d0_done, d0_pass, d0_fail;
    logic [1:0]    d0_reason;
    logic [W0-1:0] d0_count;
    logic          d1_hres, d1_dump, d1_done, d1_pass, d1_fail;
    logic [1:0]    d1_reason;
    logic [W1-1:0] d1_count;

    sim_ctrl_sequencer #(.RESET_CYCLES(RC0), .CNT_W(W0)) u_dut0 (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid),
        .max_cycles(max_cycles), .dump_start(dump_start),
        .success_in(success_in), .failure_in(failure_in),
        .harness_resetn(d0_hres), .dump_en(d0_dump), .done(d0_done),
        .pass(d0_pass), .fail(d0_fail), .reason(d0_reason), .cycle_count(d0_count)
    );

    sim_ctrl_sequencer #(.RESET_CYCLES(RC1), .CNT_W(W1)) u_dut1 (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid),
        .max_cycles(max_cycles[W1-1:0]), .dump_start(dump_start[W1-1:0]),
        .success_in(success_in), .failure_in(failure_in),
        .harness_resetn(d1_hres), .dump_en(d1_dump), .done(d1_done),
        .pass(d1_pass), .fail(d1_fail), .reason(d1_reason), .cycle_count(d1_count)
    );

    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: n = edges spent alive since release; everything else follows from n.
    longint unsigned m_n[2]    = '{0, 0};
    longint unsigned m_max[2]  = '{0, 0};
    longint unsigned m_ds[2]   = '{0, 0};
    bit              m_term[2] = '{0, 0};
    bit              m_pass[2] = '{0, 0};
    bit              m_fail[2] = '{0, 0};
    bit              m_dump[2] = '{0, 0};
    int unsigned     m_rsn[2]  = '{0, 0};

    function automatic longint unsigned mask_of(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned sat(input longint unsigned n, input int unsigned w);
        return (n > mask_of(w)) ? mask_of(w) : n;
    endfunction

    always @(posedge clock or posedge reset) begin
        longint unsigned pre;
        int unsigned     rc;
        int unsigned     w;
        for (int i = 0; i < 2; i++) begin
            rc = (i == 0) ? RC0 : RC1;
            w  = (i == 0) ? W0 : W1;
            if (reset) begin
                m_n[i] = 0; m_max[i] = 0; m_ds[i] = 0; m_term[i] = 0;
                m_pass[i] = 0; m_fail[i] = 0; m_dump[i] = 0; m_rsn[i] = 0;
            end else if (!m_term[i]) begin
                pre = sat(m_n[i], w);
                if (m_n[i] < rc) begin
                    if (cfg_valid) begin
                        m_max[i] = 64'(max_cycles) & mask_of(w);
                        m_ds[i]  = 64'(dump_start) & mask_of(w);
                    end
                end else if (failure_in) begin
                    m_term[i] = 1; m_fail[i] = 1; m_rsn[i] = 1;
                end else if (m_max[i] != 0 && pre > m_max[i]) begin
                    m_term[i] = 1; m_fail[i] = 1; m_rsn[i] = 2;
                end else if (success_in) begin
                    m_term[i] = 1; m_pass[i] = 1; m_rsn[i] = 0;
                end
                m_n[i]++;
                m_dump[i] = !m_term[i] && (m_ds[i] == 0 || pre >= m_ds[i]);
            end
        end
    end

    task automatic cmp(input int i, input longint unsigned cnt, input logic hres, input logic dmp,
                       input logic dn, input logic ps, input logic fl, input logic [1:0] rsn);
        int unsigned rc;
        int unsigned w;
        rc = (i == 0) ? RC0 : RC1;
        w  = (i == 0) ? W0 : W1;
        check($sformatf("d%0d.cycle_count", i), cnt, sat(m_n[i], w));
        check($sformatf("d%0d.harness_resetn", i), 64'(hres), 64'(m_n[i] >= rc));
        check($sformatf("d%0d.dump_en", i), 64'(dmp), 64'(m_dump[i]));
        check($sformatf("d%0d.done", i), 64'(dn), 64'(m_term[i]));
        check($sformatf("d%0d.pass", i), 64'(ps), 64'(m_pass[i]));
        check($sformatf("d%0d.fail", i), 64'(fl), 64'(m_fail[i]));
        check($sformatf("d%0d.reason", i), 64'(rsn), 64'(m_rsn[i]));
    endtask

    always @(negedge clock) begin
        cmp(0, 64'(d0_count), d0_hres, d0_dump, d0_done, d0_pass, d0_fail, d0_reason);
        cmp(1, 64'(d1_count), d1_hres, d1_dump, d1_done, d1_pass, d1_fail, d1_reason);
    end

    // Stimulus plan for one run, indexed by cycles since release.
    int unsigned cyc = 0;
    int unsigned p_cfg_at, p_mx, p_ds, p_slo, p_shi, p_fx, p_late_at, p_late_mx;

    task automatic plan(input int unsigned cfg_at, input int unsigned mx, input int unsigned ds,
                        input int unsigned slo, input int unsigned shi, input int unsigned fx,
                        input int unsigned late_at, input int unsigned late_mx);
        p_cfg_at = cfg_at; p_mx = mx; p_ds = ds; p_slo = slo; p_shi = shi;
        p_fx = fx; p_late_at = late_at; p_late_mx = late_mx;
    endtask

    task automatic drive();
        cfg_valid  = (cyc == p_cfg_at) || (cyc == p_late_at);
        max_cycles = (cyc == p_late_at) ? W0'(p_late_mx) : W0'(p_mx);
        dump_start = W0'(p_ds);
        success_in = (cyc >= p_slo) && (cyc <= p_shi);
        failure_in = (cyc == p_fx);
    endtask

    task automatic start_run();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
        drive();
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            drive();
        end
    endtask

    // Raise reset between edges and confirm the outputs clear without waiting for a clock.
    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1;
        check("async.cycle_count", 64'(d0_count), 0);
        check("async.harness_resetn", 64'(d0_hres), 0);
        check("async.dump_en", 64'(d0_dump), 0);
        check("async.done", 64'({d0_done, d0_pass, d0_fail}), 0);
        check("async.reason", 64'(d0_reason), 0);
        check("async.d1_count", 64'(d1_count), 0);
    endtask

    initial begin
        #1 reset = 1'b1;

        // Basic pass: success pulsed while cycle_count==20.
        plan(NONE, 0, 0, 20, 20, NONE, NONE, 0);
        start_run();
        step(3);
        check("lit.hres_cycle3", 64'(d0_hres), 0);
        step(1);
        check("lit.hres_cycle4", 64'(d0_hres), 1);
        step(21);
        check("lit.pass_count", 64'(d0_count), 21);
        check("lit.pass", 64'({d0_done, d0_pass, d0_fail}), 3'b110);
        check("lit.pass_reason", 64'(d0_reason), 0);
        async_reset_check();

        // Timeout at max_cycles=10.
        plan(0, 10, 0, NONE, NONE, NONE, NONE, 0);
        start_run();
        step(20);
        check("lit.timeout_count", 64'(d0_count), 12);
        check("lit.timeout_fail", 64'({d0_pass, d0_fail}), 2'b01);
        check("lit.timeout_reason", 64'(d0_reason), 2);
        check("lit.timeout_dump", 64'(d0_dump), 0);
        async_reset_check();

        // Success, failure and timeout on the same edge.
        plan(0, 10, 0, 11, 11, 11, NONE, 0);
        start_run();
        step(15);
        check("lit.simul_reason", 64'(d0_reason), 1);
        check("lit.simul_fail", 64'({d0_pass, d0_fail}), 2'b01);
        async_reset_check();

        // Dump window starting at 8.
        plan(0, 0, 8, 20, 20, NONE, NONE, 0);
        start_run();
        step(8);
        check("lit.dump_at8", 64'(d0_dump), 0);
        step(1);
        check("lit.dump_at9", 64'(d0_dump), 1);
        step(16);
        check("lit.dump_after_end", 64'(d0_dump), 0);
        async_reset_check();

        // Dump from release, then reset mid-run at cycle 15.
        plan(NONE, 0, 0, NONE, NONE, NONE, NONE, 0);
        start_run();
        step(1);
        check("lit.dump_from_release", 64'(d0_dump), 1);
        step(14);
        async_reset_check();

        // Success during HOLD ignored, late cfg in RUN ignored, saturation on the 4-bit instance.
        plan(NONE, 0, 0, 1, 2, NONE, 6, 5);
        start_run();
        step(3);
        check("lit.hold_filter_done", 64'(d0_done), 0);
        step(27);
        check("lit.late_cfg_done", 64'(d0_done), 0);
        check("lit.late_cfg_count", 64'(d0_count), 30);
        check("lit.sat_count", 64'(d1_count), 15);
        async_reset_check();

        for (int r = 0; r < 20; r++) begin
            plan($urandom_range(0, 5),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 40),
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40),
                 0, 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(2, 50) : NONE,
                 ($urandom_range(0, 1) == 0) ? $urandom_range(0, 30) : NONE,
                 $urandom_range(1, 20));
            p_slo = $urandom_range(1, 50);
            p_shi = p_slo + $urandom_range(0, 3);
            start_run();
            step($urandom_range(20, 60));
            async_reset_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
